// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  // Access size encodings as presented on req_size.
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DATA   = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_t;

  // True when the request can never reach the RAM: illegal size or an
  // address that is not naturally aligned for the requested size.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends sub-word
// load data, and merges sub-word store data into the old RAM word.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    if (lo[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          2'd3:    r[31:24] = wdata[7:0];
          default: r        = old;
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      SZ_WORD: r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  // Both results are always computed; the FSM chooses which one it uses.
  always_comb begin
    load_o  = load_extract(word_i, lane_i, size_i, unsigned_i);
    merge_o = store_merge(word_i, wdata_i, lane_i, size_i);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access at a time against a
// single-port word RAM with one-cycle read latency. Sub-word stores are
// done as read-modify-write of the containing word.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  lsu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  wen_q, wen_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] align_load;
  logic [DATA_WIDTH-1:0] align_merge;

  // Lane logic always looks at the RAM read port and the latched request.
  lsu_align u_align (
    .word_i     (ram_out),
    .wdata_i    (wdata_q),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (align_load),
    .merge_o    (align_merge)
  );

  // Next-state, request latching, response capture and RAM write decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wen_d   = wen_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_wen = 1'b0;
    ram_in  = {DATA_WIDTH{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wen_d   = req_wen;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (req_is_bad(req_size, req_addr[1:0])) begin
            // Rejected without touching the RAM.
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (wen_q && (size_q == SZ_WORD)) begin
          // Full-word store needs no read of the old word.
          ram_wen = 1'b1;
          ram_in  = wdata_q;
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          // Address is presented now; read data arrives in DATA.
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        state_d = ST_RESP;
        err_d   = 1'b0;
        if (wen_q) begin
          ram_wen = 1'b1;
          ram_in  = align_merge;
          rdata_d = {DATA_WIDTH{1'b0}};
        end else begin
          rdata_d = align_load;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request/response registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      size_q  <= SZ_BYTE;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake and response outputs are direct decodes of registered state.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    ram_addr   = addr_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic
// compared against a word-array reference model of memory and responses.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_in;
  logic        ram_wen;
  logic [31:0] ram_out;

  int vec  = 0;
  int errs = 0;

  logic [31:0] ram [0:1023];
  bit   [31:0] model_mem [0:1023];

  typedef struct packed {
    bit        wen;
    bit [1:0]  size;
    bit        uns;
    bit [11:0] addr;
    bit [31:0] wdata;
    int        lat;
    bit [31:0] rdata;
    bit        err;
    int        wcnt;
  } op_t;

  lsu #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .ram_addr(ram_addr), .ram_in(ram_in),
    .ram_wen(ram_wen), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Single-port word RAM, registered read, address bits [1:0] ignored.
  always @(posedge clk) begin
    if (ram_wen) ram[ram_addr[11:2]] <= ram_in;
    ram_out <= ram[ram_addr[11:2]];
  end

  // Reference: natural-alignment rule, little-endian lanes, masked merge.
  function automatic void model_op(input bit wen, input bit [1:0] size, input bit uns,
                                   input bit [11:0] addr, input bit [31:0] wdata,
                                   output int lat, output bit [31:0] rdata,
                                   output bit err, output int wcnt);
    int nb, sh, idx;
    bit [63:0] lm;
    bit [31:0] mask, word;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    sh    = 8 * (int'(addr) % 4);
    idx   = int'(addr) / 4;
    lm    = (64'd1 << (8 * nb)) - 64'd1;
    mask  = 32'(lm << sh);
    err   = (size == 2'd3) || ((int'(addr) % nb) != 0);
    rdata = 32'h0;
    wcnt  = 0;
    if (err) begin
      lat = 1;
    end else if (wen) begin
      word = model_mem[idx];
      model_mem[idx] = (word & ~mask) | ((wdata << sh) & mask);
      lat  = (nb == 4) ? 2 : 3;
      wcnt = 1;
    end else begin
      rdata = 32'(model_mem[idx] >> sh) & 32'(lm);
      if (!uns && nb < 4 && rdata[8*nb-1]) rdata = rdata | ~32'(lm);
      lat = 3;
    end
  endfunction

  // Issue one request from IDLE (called at a negedge); measures latency in
  // edges counted from the accept edge, captures the response, counts ram_wen cycles.
  task automatic do_req(input bit wen, input bit [1:0] size, input bit uns,
                        input bit [11:0] addr, input bit [31:0] wdata,
                        output int lat, output bit [31:0] rdata,
                        output bit err, output int wcnt);
    lat = 0; rdata = 32'h0; err = 1'b0; wcnt = 0;
    req_valid = 1'b1; req_wen = wen; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (ram_wen) wcnt++;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
      end
      if (k == 1) begin
        req_valid = 1'b0; req_wen = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset req_ready got %b exp 1", req_ready); end
    vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset resp_valid got %b exp 0", resp_valid); end
    vec++; if (resp_err !== 1'b0) begin errs++; $display("FAIL reset resp_err got %b exp 0", resp_err); end
    vec++; if (resp_rdata !== 32'h0) begin errs++; $display("FAIL reset resp_rdata got %h exp 0", resp_rdata); end
    vec++; if (ram_wen !== 1'b0) begin errs++; $display("FAIL reset ram_wen got %b exp 0", ram_wen); end
    vec++; if (ram_addr !== 12'h0) begin errs++; $display("FAIL reset ram_addr got %h exp 0", ram_addr); end
    vec++; if (ram_in !== 32'h0) begin errs++; $display("FAIL reset ram_in got %h exp 0", ram_in); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Directed table runner body is repeated inline in each scenario below.
  task automatic test_word();
    op_t ops [2];
    int lat, ml, wc, mw; bit [31:0] rd, mr; bit er, me;
    ops[0] = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1};
    ops[1] = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        3, 32'hDEADBEEF, 1'b0, 0};
    for (int i = 0; i < 2; i++) begin
      do_req(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, er, wc);
      model_op(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, ml, mr, me, mw);
      vec++; if (lat !== ops[i].lat) begin errs++; $display("FAIL word[%0d] latency got %0d exp %0d", i, lat, ops[i].lat); end
      vec++; if (rd !== ops[i].rdata) begin errs++; $display("FAIL word[%0d] rdata got %h exp %h", i, rd, ops[i].rdata); end
      vec++; if (er !== ops[i].err) begin errs++; $display("FAIL word[%0d] err got %b exp %b", i, er, ops[i].err); end
      vec++; if (wc !== ops[i].wcnt) begin errs++; $display("FAIL word[%0d] wen_cycles got %0d exp %0d", i, wc, ops[i].wcnt); end
    end
    vec++; if (ram[4] !== 32'hDEADBEEF) begin errs++; $display("FAIL word ram@010 got %h exp deadbeef", ram[4]); end
  endtask

  task automatic test_byte();
    op_t ops [4];
    int lat, ml, wc, mw; bit [31:0] rd, mr; bit er, me;
    ops[0] = '{1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344, 2, 32'h0, 1'b0, 1};
    ops[1] = '{1'b1, 2'd0, 1'b0, 12'h023, 32'h000000A5, 3, 32'h0, 1'b0, 1};
    ops[2] = '{1'b0, 2'd0, 1'b0, 12'h023, 32'h0, 3, 32'hFFFFFFA5, 1'b0, 0};
    ops[3] = '{1'b0, 2'd0, 1'b1, 12'h023, 32'h0, 3, 32'h000000A5, 1'b0, 0};
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, er, wc);
      model_op(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, ml, mr, me, mw);
      vec++; if (lat !== ops[i].lat) begin errs++; $display("FAIL byte[%0d] latency got %0d exp %0d", i, lat, ops[i].lat); end
      vec++; if (rd !== ops[i].rdata) begin errs++; $display("FAIL byte[%0d] rdata got %h exp %h", i, rd, ops[i].rdata); end
      vec++; if (er !== ops[i].err) begin errs++; $display("FAIL byte[%0d] err got %b exp %b", i, er, ops[i].err); end
      vec++; if (wc !== ops[i].wcnt) begin errs++; $display("FAIL byte[%0d] wen_cycles got %0d exp %0d", i, wc, ops[i].wcnt); end
    end
    vec++; if (ram[8] !== 32'hA5223344) begin errs++; $display("FAIL byte ram@020 got %h exp a5223344", ram[8]); end
  endtask

  task automatic test_half();
    op_t ops [4];
    int lat, ml, wc, mw; bit [31:0] rd, mr; bit er, me;
    ops[0] = '{1'b1, 2'd2, 1'b0, 12'h030, 32'h0, 2, 32'h0, 1'b0, 1};
    ops[1] = '{1'b1, 2'd1, 1'b0, 12'h032, 32'h00008001, 3, 32'h0, 1'b0, 1};
    ops[2] = '{1'b0, 2'd1, 1'b0, 12'h032, 32'h0, 3, 32'hFFFF8001, 1'b0, 0};
    ops[3] = '{1'b0, 2'd1, 1'b1, 12'h032, 32'h0, 3, 32'h00008001, 1'b0, 0};
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, er, wc);
      model_op(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, ml, mr, me, mw);
      vec++; if (lat !== ops[i].lat) begin errs++; $display("FAIL half[%0d] latency got %0d exp %0d", i, lat, ops[i].lat); end
      vec++; if (rd !== ops[i].rdata) begin errs++; $display("FAIL half[%0d] rdata got %h exp %h", i, rd, ops[i].rdata); end
      vec++; if (er !== ops[i].err) begin errs++; $display("FAIL half[%0d] err got %b exp %b", i, er, ops[i].err); end
      vec++; if (wc !== ops[i].wcnt) begin errs++; $display("FAIL half[%0d] wen_cycles got %0d exp %0d", i, wc, ops[i].wcnt); end
    end
    vec++; if (ram[12] !== 32'h80010000) begin errs++; $display("FAIL half ram@030 got %h exp 80010000", ram[12]); end
  endtask

  task automatic test_errors();
    op_t ops [3];
    int lat, ml, wc, mw; bit [31:0] rd, mr; bit er, me;
    ops[0] = '{1'b0, 2'd2, 1'b0, 12'h011, 32'h0,        1, 32'h0, 1'b1, 0};
    ops[1] = '{1'b1, 2'd1, 1'b0, 12'h015, 32'h0000BEEF, 1, 32'h0, 1'b1, 0};
    ops[2] = '{1'b1, 2'd3, 1'b0, 12'h040, 32'h12345678, 1, 32'h0, 1'b1, 0};
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, lat, rd, er, wc);
      model_op(ops[i].wen, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, ml, mr, me, mw);
      vec++; if (lat !== ops[i].lat) begin errs++; $display("FAIL err[%0d] latency got %0d exp %0d", i, lat, ops[i].lat); end
      vec++; if (rd !== ops[i].rdata) begin errs++; $display("FAIL err[%0d] rdata got %h exp %h", i, rd, ops[i].rdata); end
      vec++; if (er !== ops[i].err) begin errs++; $display("FAIL err[%0d] err got %b exp %b", i, er, ops[i].err); end
      vec++; if (wc !== ops[i].wcnt) begin errs++; $display("FAIL err[%0d] wen_cycles got %0d exp %0d", i, wc, ops[i].wcnt); end
    end
    vec++; if (ram[4] !== 32'hDEADBEEF) begin errs++; $display("FAIL err ram@010 got %h exp deadbeef", ram[4]); end
  endtask

  // req_valid held high across two loads: second accepted only after RESP+IDLE.
  task automatic test_back_to_back();
    int la, lb, wc, pulses;
    bit [31:0] ra, rb; bit ea, eb;
    bit exp_rdy, exp_rv;
    model_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, la, ra, ea, wc);
    model_op(1'b0, 2'd0, 1'b1, 12'h021, 32'h0, lb, rb, eb, wc);
    pulses = 0;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 12'h010; req_wdata = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_rdy = (k == la + 1) || (k >= la + lb + 2);
      exp_rv  = (k == la) || (k == la + 1 + lb);
      vec++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL b2b req_ready k=%0d got %b exp %b", k, req_ready, exp_rdy); end
      vec++; if (resp_valid !== exp_rv) begin errs++; $display("FAIL b2b resp_valid k=%0d got %b exp %b", k, resp_valid, exp_rv); end
      if (resp_valid) begin
        vec++;
        if (resp_rdata !== ((pulses == 0) ? ra : rb)) begin
          errs++; $display("FAIL b2b rdata#%0d got %h exp %h", pulses, resp_rdata, (pulses == 0) ? ra : rb);
        end
        pulses++;
      end
      if (k == 1) begin
        req_size = 2'd0; req_unsigned = 1'b1; req_addr = 12'h021;
      end
      if (k == 5) req_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    int lat, ml, wc, mw; bit [31:0] rd, mr; bit er, me;
    bit wen, uns; bit [1:0] size; bit [11:0] addr; bit [31:0] wdata;
    for (int i = 0; i < 96; i++) begin
      if (i < 16) begin
        wen = 1'b1; size = 2'd2; uns = 1'b0; addr = 12'h100 + 12'(4 * i); wdata = $urandom;
      end else begin
        wen = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = 12'h100 + 12'($urandom_range(0, 63)); wdata = $urandom;
      end
      do_req(wen, size, uns, addr, wdata, lat, rd, er, wc);
      model_op(wen, size, uns, addr, wdata, ml, mr, me, mw);
      vec++; if (lat !== ml) begin errs++; $display("FAIL rand[%0d] latency got %0d exp %0d", i, lat, ml); end
      vec++; if (rd !== mr) begin errs++; $display("FAIL rand[%0d] rdata got %h exp %h", i, rd, mr); end
      vec++; if (er !== me) begin errs++; $display("FAIL rand[%0d] err got %b exp %b", i, er, me); end
      vec++; if (wc !== mw) begin errs++; $display("FAIL rand[%0d] wen_cycles got %0d exp %0d", i, wc, mw); end
    end
    for (int w = 64; w < 80; w++) begin
      vec++; if (ram[w] !== model_mem[w]) begin errs++; $display("FAIL rand ram[%0d] got %h exp %h", w, ram[w], model_mem[w]); end
    end
  endtask

  // Byte store aborted by reset in DATA: write must not happen.
  task automatic test_reset_mid();
    int lat, ml, wc, mw, late; bit [31:0] rd, mr; bit er, me;
    do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344, lat, rd, er, wc);
    model_op(1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344, ml, mr, me, mw);
    vec++; if (lat !== 2) begin errs++; $display("FAIL rstmid preload latency got %0d exp 2", lat); end
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 12'h023; req_wdata = 32'h000000A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vec++; if (ram_wen !== 1'b0) begin errs++; $display("FAIL rstmid access ram_wen got %b exp 0", ram_wen); end
    @(negedge clk);
    vec++; if (ram_wen !== 1'b1) begin errs++; $display("FAIL rstmid data ram_wen got %b exp 1", ram_wen); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if (ram_wen !== 1'b0) begin errs++; $display("FAIL rstmid async ram_wen got %b exp 0", ram_wen); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rstmid req_ready got %b exp 1", req_ready); end
    vec++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL rstmid resp_valid got %b exp 0", resp_valid); end
    late = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) late++;
    end
    vec++; if (late !== 0) begin errs++; $display("FAIL rstmid stray resp_valid cycles got %0d exp 0", late); end
    vec++; if (ram[8] !== 32'h11223344) begin errs++; $display("FAIL rstmid ram@020 got %h exp 11223344", ram[8]); end
    do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, lat, rd, er, wc);
    vec++; if (rd !== 32'h11223344) begin errs++; $display("FAIL rstmid reload got %h exp 11223344", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
